// File: rtl/sub_pkg.sv
// Shared constants and result type for the subtract datapath and its harnesses.
package sub_pkg;
  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SPLIT = 16;
  localparam int unsigned HIGH_W    = DEF_WIDTH - DEF_SPLIT;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] diff;
    logic                 bout;
    logic                 of;
  } sub_result_t;
endpackage

// File: rtl/ripple_subtractor.sv
// Combinational N-bit ripple-borrow subtractor: diff = a - b - bin.
module ripple_subtractor #(
  parameter int unsigned N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);
  logic [N:0] br;

  always_comb begin
    br    = '0;
    br[0] = bin;
    diff  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[N];
  end
endmodule

// File: rtl/carry_decrement_subtractor.sv
// Two-stage valid/ready subtractor; the high half is computed with borrow-in 0 and
// fixed up by a decrement chain in stage 2 when the low half borrows.
module carry_decrement_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SPLIT = DEF_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             of
);
  localparam int unsigned HI_W = WIDTH - SPLIT;

  logic [SPLIT-1:0] low_diff;
  logic             low_borrow;
  logic [HI_W-1:0]  hi_raw;
  logic             hi_borrow;

  ripple_subtractor #(.N(SPLIT)) u_low (
    .a(a[SPLIT-1:0]), .b(b[SPLIT-1:0]), .bin(bin), .diff(low_diff), .bout(low_borrow)
  );

  ripple_subtractor #(.N(HI_W)) u_high (
    .a(a[WIDTH-1:SPLIT]), .b(b[WIDTH-1:SPLIT]), .bin(1'b0), .diff(hi_raw), .bout(hi_borrow)
  );

  logic             s1_valid;
  logic [SPLIT-1:0] s1_low;
  logic             s1_bl;
  logic [HI_W-1:0]  s1_t;
  logic             s1_bh;
  logic             s1_am;
  logic             s1_bm;
  logic             s2_valid;

  logic             s1_en;
  logic             s2_en;

  assign s2_en     = ~s2_valid | out_ready;
  assign s1_en     = ~s1_valid | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;

  // Decrement chain: bit i flips while the low borrow is still propagating through zeros
  logic [HI_W-1:0]  hi_fix;
  logic             run;
  logic [WIDTH-1:0] fix_diff;
  logic             fix_bout;
  logic             fix_of;

  always_comb begin
    run    = s1_bl;
    hi_fix = '0;
    for (int unsigned i = 0; i < HI_W; i++) begin
      hi_fix[i] = s1_t[i] ^ run;
      run       = run & ~s1_t[i];
    end
    fix_bout = s1_bh | run;
    fix_diff = {hi_fix, s1_low};
    fix_of   = (s1_am ^ s1_bm) & (s1_am ^ hi_fix[HI_W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_low   <= '0;
      s1_bl    <= 1'b0;
      s1_t     <= '0;
      s1_bh    <= 1'b0;
      s1_am    <= 1'b0;
      s1_bm    <= 1'b0;
      s2_valid <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      of       <= 1'b0;
    end else begin
      if (s1_en) begin
        s1_valid <= in_valid;
        s1_low   <= low_diff;
        s1_bl    <= low_borrow;
        s1_t     <= hi_raw;
        s1_bh    <= hi_borrow;
        s1_am    <= a[WIDTH-1];
        s1_bm    <= b[WIDTH-1];
      end
      if (s2_en) begin
        s2_valid <= s1_valid;
        diff     <= fix_diff;
        bout     <= fix_bout;
        of       <= fix_of;
      end
    end
  end
endmodule
